// File: rtl/hex_ascii_to_binary.sv
// ---------------------------------------------------------------------------
// hex_ascii_to_binary
//
// Purpose:
//   Collects a stream of ASCII hexadecimal characters, most-significant nibble
//   first, and assembles every eight digits into one 32-bit binary word. The
//   word is then offered downstream with a valid/ready handshake. Upper-case and
//   lower-case letters are both accepted. Any other character is rejected. A
//   rejected character discards the partial word, pulses err for one cycle and
//   is kept in err_char.
//
// Ports:
//   clk        in   1  system clock, all state updates on the rising edge
//   rst        in   1  synchronous active-high reset
//   char_in    in   8  ASCII character offered
//   char_valid in   1  char_in is offered this cycle
//   char_ready out  1  a character can be accepted this cycle
//   word_out   out 32  assembled binary word
//   word_valid out  1  word_out holds a complete, unconsumed word
//   word_ready in   1  downstream consumes word_out this cycle
//   digit_cnt  out  4  hex digits accumulated in the current word (0..8)
//   err        out  1  one-cycle pulse: an invalid character was rejected
//   err_char   out  8  last invalid character received
// ---------------------------------------------------------------------------
module hex_ascii_to_binary (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [31:0] word_out,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [3:0]  digit_cnt,
  output logic        err,
  output logic [7:0]  err_char
);

  // ACCUM collects digits. HOLD means a completed word is waiting for the consumer.
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] word_q, word_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [7:0]  err_char_q, err_char_d;

  logic        is_hex;
  logic [3:0]  nibble;
  logic        char_fire;
  logic        word_fire;
  logic [31:0] shifted;

  // Character decode. A letter's value is its low ASCII nibble plus nine.
  // This works for both 'A'..'F' (0x41..0x46) and 'a'..'f' (0x61..0x66).
  always_comb begin
    is_hex = 1'b0;
    nibble = 4'd0;
    if (char_in >= 8'h30 && char_in <= 8'h39) begin
      is_hex = 1'b1;
      nibble = char_in[3:0];
    end else if ((char_in >= 8'h41 && char_in <= 8'h46) ||
                 (char_in >= 8'h61 && char_in <= 8'h66)) begin
      is_hex = 1'b1;
      nibble = char_in[3:0] + 4'd9;
    end
  end

  // The handshake signals come only from the registered state.
  // Because of this, char_ready does not depend combinationally on any input.
  assign char_ready = (state_q == ACCUM);
  assign word_valid = (state_q == HOLD);
  assign char_fire  = char_valid && char_ready;
  assign word_fire  = word_valid && word_ready;
  assign shifted    = {shift_q[27:0], nibble};

  // Next-state logic.
  // - In ACCUM, an accepted digit shifts into the register.
  // - The eighth digit goes straight into word_out instead, and the block
  //   moves to HOLD. This gives word_valid the cycle after the last digit.
  // - An accepted invalid character flushes the partial word and stays in ACCUM.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    word_d     = word_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    err_char_d = err_char_q;

    case (state_q)
      ACCUM: begin
        if (char_fire) begin
          if (is_hex) begin
            if (cnt_q == 4'd7) begin
              word_d  = shifted;
              shift_d = 32'd0;
              cnt_d   = 4'd0;
              state_d = HOLD;
            end else begin
              shift_d = shifted;
              cnt_d   = cnt_q + 4'd1;
            end
          end else begin
            err_d      = 1'b1;
            err_char_d = char_in;
            shift_d    = 32'd0;
            cnt_d      = 4'd0;
          end
        end
      end
      HOLD: begin
        // word_out is left untouched here. It keeps the consumed value
        // until the next word completes.
        if (word_fire) begin
          state_d = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // State registers. Reset wins over every handshake.
  // This means a partial or pending word is simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ACCUM;
      shift_q    <= 32'd0;
      word_q     <= 32'd0;
      cnt_q      <= 4'd0;
      err_q      <= 1'b0;
      err_char_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      word_q     <= word_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      err_char_q <= err_char_d;
    end
  end

  assign word_out  = word_q;
  assign digit_cnt = cnt_q;
  assign err       = err_q;
  assign err_char  = err_char_q;

endmodule

// File: tb/tb_hex_ascii_to_binary.sv
// ---------------------------------------------------------------------------
// tb_hex_ascii_to_binary
//
// Purpose:
//   Directed self-checking bench for hex_ascii_to_binary. Inputs change 1 ns
//   after a rising edge, and outputs are sampled at that same point.
//   Each character therefore takes effect at the next rising edge.
// ---------------------------------------------------------------------------
module tb_hex_ascii_to_binary;

  logic        clk;
  logic        rst;
  logic [7:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic [3:0]  digit_cnt;
  logic        err;
  logic [7:0]  err_char;

  int n_checks;
  int n_fail;

  hex_ascii_to_binary dut (
    .clk        (clk),
    .rst        (rst),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .digit_cnt  (digit_cnt),
    .err        (err),
    .err_char   (err_char)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one character for exactly one edge, leaving char_valid asserted.
  task automatic send_one(input logic [7:0] c);
    char_valid = 1'b1;
    char_in    = c;
    step();
  endtask

  // Offer a whole string back-to-back, then drop char_valid before the next edge.
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      send_one(s[i]);
    end
    char_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    char_valid = 1'b0;
    char_in = 8'h00;
    word_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_checks++;
    if (word_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_word_valid: got %0b expected 0", word_valid); end
    n_checks++;
    if (char_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_char_ready: got %0b expected 1", char_ready); end
    n_checks++;
    if (word_out !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_word_out: got %h expected 00000000", word_out); end
    n_checks++;
    if (digit_cnt !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_digit_cnt: got %0d expected 0", digit_cnt); end
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %0b expected 0", err); end
    n_checks++;
    if (err_char !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_err_char: got %h expected 00", err_char); end
  endtask

  task automatic test_upper_case();
    string s = "1234ABCD";
    word_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send_one(s[i]);
      n_checks++;
      if (digit_cnt !== 4'(i + 1)) begin n_fail++; $display("[TB] FAIL upper_digit_cnt[%0d]: got %0d expected %0d", i, digit_cnt, i + 1); end
      n_checks++;
      if (word_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL upper_early_valid[%0d]: got %0b expected 0", i, word_valid); end
    end
    send_one(s[7]);
    char_valid = 1'b0;
    n_checks++;
    if (word_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL upper_word_valid: got %0b expected 1", word_valid); end
    n_checks++;
    if (word_out !== 32'h1234ABCD) begin n_fail++; $display("[TB] FAIL upper_word_out: got %h expected 1234abcd", word_out); end
    n_checks++;
    if (char_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL upper_char_ready_hold: got %0b expected 0", char_ready); end
    n_checks++;
    if (digit_cnt !== 4'd0) begin n_fail++; $display("[TB] FAIL upper_cnt_cleared: got %0d expected 0", digit_cnt); end
    step();
    n_checks++;
    if (word_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL upper_one_cycle: got %0b expected 0", word_valid); end
    n_checks++;
    if (char_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL upper_ready_back: got %0b expected 1", char_ready); end
    n_checks++;
    if (word_out !== 32'h1234ABCD) begin n_fail++; $display("[TB] FAIL upper_word_retained: got %h expected 1234abcd", word_out); end
  endtask

  task automatic test_lower_case();
    word_ready = 1'b1;
    send_str("deadbeef");
    n_checks++;
    if (word_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL lower_word_valid: got %0b expected 1", word_valid); end
    n_checks++;
    if (word_out !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL lower_word_out: got %h expected deadbeef", word_out); end
    step();
  endtask

  task automatic test_error();
    word_ready = 1'b1;
    send_one("1");
    send_one("2");
    send_one("G");
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL err_pulse: got %0b expected 1", err); end
    n_checks++;
    if (err_char !== 8'h47) begin n_fail++; $display("[TB] FAIL err_char: got %h expected 47", err_char); end
    n_checks++;
    if (digit_cnt !== 4'd0) begin n_fail++; $display("[TB] FAIL err_cnt_cleared: got %0d expected 0", digit_cnt); end
    n_checks++;
    if (word_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL err_no_word: got %0b expected 0", word_valid); end
    send_one("4");
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL err_single_cycle: got %0b expected 0", err); end
    n_checks++;
    if (digit_cnt !== 4'd1) begin n_fail++; $display("[TB] FAIL err_restart_cnt: got %0d expected 1", digit_cnt); end
    // Two back-to-back invalid characters flush the lone '4'.
    // Each one must pulse err on its own cycle.
    send_one("x");
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL err_b2b_first: got %0b expected 1", err); end
    send_one(":");
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL err_b2b_second: got %0b expected 1", err); end
    n_checks++;
    if (err_char !== 8'h3A) begin n_fail++; $display("[TB] FAIL err_char_latest: got %h expected 3a", err_char); end
    n_checks++;
    if (digit_cnt !== 4'd0) begin n_fail++; $display("[TB] FAIL err_zero_cnt: got %0d expected 0", digit_cnt); end
    send_str("0000FFFF");
    n_checks++;
    if (word_out !== 32'h0000FFFF || word_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL err_recover_word: got %h/%0b expected 0000ffff/1", word_out, word_valid); end
    n_checks++;
    if (err_char !== 8'h3A) begin n_fail++; $display("[TB] FAIL err_char_sticky: got %h expected 3a", err_char); end
    step();
  endtask

  task automatic test_back_pressure();
    word_ready = 1'b0;
    send_str("CAFEF00D");
    n_checks++;
    if (word_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_word_valid: got %0b expected 1", word_valid); end
    char_valid = 1'b1;
    char_in = "9";
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (word_valid !== 1'b1 || char_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_hold[%0d]: got valid=%0b ready=%0b expected valid=1 ready=0", i, word_valid, char_ready); end
      n_checks++;
      if (word_out !== 32'hCAFEF00D || digit_cnt !== 4'd0 || err !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_stable[%0d]: got word=%h cnt=%0d err=%0b expected cafef00d/0/0", i, word_out, digit_cnt, err); end
    end
    word_ready = 1'b1;
    step();
    n_checks++;
    if (word_valid !== 1'b0 || char_ready !== 1'b1 || digit_cnt !== 4'd0) begin n_fail++; $display("[TB] FAIL bp_consume: got valid=%0b ready=%0b cnt=%0d expected 0/1/0", word_valid, char_ready, digit_cnt); end
    step();
    char_valid = 1'b0;
    n_checks++;
    if (digit_cnt !== 4'd1) begin n_fail++; $display("[TB] FAIL bp_nine_accepted: got %0d expected 1", digit_cnt); end
  endtask

  task automatic test_reset_mid_word();
    word_ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    send_str("ABC");
    n_checks++;
    if (digit_cnt !== 4'd3) begin n_fail++; $display("[TB] FAIL rst_mid_cnt_before: got %0d expected 3", digit_cnt); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (digit_cnt !== 4'd0) begin n_fail++; $display("[TB] FAIL rst_mid_cnt_after: got %0d expected 0", digit_cnt); end
    send_str("00000001");
    n_checks++;
    if (word_out !== 32'h00000001 || word_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_mid_word: got %h/%0b expected 00000001/1", word_out, word_valid); end
    step();
    // A reset while a word is held must drop it without any transfer.
    word_ready = 1'b0;
    send_str("87654321");
    n_checks++;
    if (word_valid !== 1'b1 || word_out !== 32'h87654321) begin n_fail++; $display("[TB] FAIL rst_hold_pre: got %h/%0b expected 87654321/1", word_out, word_valid); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    word_ready = 1'b1;
    n_checks++;
    if (word_valid !== 1'b0 || word_out !== 32'h0 || char_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_hold_post: got %h/%0b/%0b expected 00000000/0/1", word_out, word_valid, char_ready); end
  endtask

  task automatic test_toggle_valid();
    word_ready = 1'b1;
    char_in = "F";
    for (int i = 0; i < 8; i++) begin
      char_valid = 1'b1;
      step();
      if (i < 7) begin
        n_checks++;
        if (word_valid !== 1'b0 || digit_cnt !== 4'(i + 1)) begin n_fail++; $display("[TB] FAIL toggle_on[%0d]: got valid=%0b cnt=%0d expected 0/%0d", i, word_valid, digit_cnt, i + 1); end
        char_valid = 1'b0;
        step();
        n_checks++;
        if (word_valid !== 1'b0 || digit_cnt !== 4'(i + 1)) begin n_fail++; $display("[TB] FAIL toggle_off[%0d]: got valid=%0b cnt=%0d expected 0/%0d", i, word_valid, digit_cnt, i + 1); end
      end
    end
    char_valid = 1'b0;
    n_checks++;
    if (word_valid !== 1'b1 || word_out !== 32'hFFFFFFFF) begin n_fail++; $display("[TB] FAIL toggle_word: got %h/%0b expected ffffffff/1", word_out, word_valid); end
    step();
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    char_valid = 1'b0;
    char_in    = 8'h00;
    word_ready = 1'b0;
    #1;
    test_reset();
    test_upper_case();
    test_lower_case();
    test_error();
    test_back_pressure();
    test_reset_mid_word();
    test_toggle_valid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hex_ascii_to_binary.md
HEX_ASCII_TO_BINARY -- requirements
Module: hex_ascii_to_binary

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use a synchronous, active-high reset; the clock port SHALL be clk and the reset port SHALL be rst.
REQ-002 The port clk SHALL be an input of width 1: the system clock; all state updates occur on the rising edge.
REQ-003 The port rst SHALL be an input of width 1: synchronous, active-high reset.
REQ-004 The port char_in SHALL be an input of width 8: the ASCII character offered.
REQ-005 The port char_valid SHALL be an input of width 1: char_in is offered this cycle.
REQ-006 The port char_ready SHALL be an output of width 1: the block can accept a character this cycle.
REQ-007 The port word_out SHALL be an output of width 32: the assembled binary word.
REQ-008 The port word_valid SHALL be an output of width 1: word_out holds a complete, unconsumed word.
REQ-009 The port word_ready SHALL be an input of width 1: the downstream block consumes word_out this cycle.
REQ-010 The port digit_cnt SHALL be an output of width 4: the number of hex digits accumulated in the current word, range 0..8.
REQ-011 The port err SHALL be an output of width 1: a one-cycle pulse indicating that an invalid character was rejected.
REQ-012 The port err_char SHALL be an output of width 8: the last invalid character received.

Function
REQ-013 A character transfer SHALL occur on a rising edge only when char_valid=1 and char_ready=1 in the same cycle.
REQ-014 A word transfer SHALL occur on a rising edge only when word_valid=1 and word_ready=1 in the same cycle.
REQ-015 The block SHALL have two states: ACCUM (collecting digits) and HOLD (word pending); in HOLD, word_valid SHALL be 1, and in ACCUM, word_valid SHALL be 0.
REQ-016 char_ready SHALL equal NOT word_valid, driven combinationally from the registered state; the block SHALL NOT accept characters while in HOLD.
REQ-017 Valid digits SHALL be 0x30-0x39 (value 0-9), 0x41-0x46 (value 10-15) and 0x61-0x66 (value 10-15); the block SHALL accept both upper and lower case.
REQ-018 Digits SHALL arrive most-significant nibble first.
REQ-019 On each accepted valid digit, the block SHALL perform: shift_reg = {shift_reg[27:0], nibble} and digit_cnt = digit_cnt + 1.
REQ-020 When the 8th digit is accepted at edge N, the block SHALL transition as follows at edge N: word_out = completed value, word_valid=1, state to HOLD, digit_cnt to 0 (latency of 1 cycle from the final character to word_valid).
REQ-021 word_out SHALL remain stable while word_valid=1.
REQ-022 In HOLD, on a word transfer the block SHALL set word_valid to 0 and the state to ACCUM at that edge; char_ready SHALL then be 1 in the following cycle.
REQ-023 If word_valid=1 and word_ready=0, the block SHALL hold word_valid and word_out indefinitely; no character SHALL be accepted or lost during this time.
REQ-024 On an accepted invalid character, at that edge the block SHALL: set err=1 for exactly one cycle, load err_char with char_in, clear shift_reg and digit_cnt to 0, and remain in ACCUM.
REQ-025 An invalid character received while digit_cnt=0 SHALL still pulse err and SHALL leave the shift register at zero.
REQ-026 Characters presented while char_ready=0 SHALL be ignored and SHALL NOT raise err.
REQ-027 err SHALL be 0 in every cycle without an accepted invalid character; back-to-back invalid characters SHALL produce err=1 on consecutive cycles.
REQ-028 word_out SHALL retain its last value after consumption until the next word completes.

Reset
REQ-029 While rst=1 at a rising edge, the block SHALL set: state=ACCUM, word_out=0x00000000, word_valid=0, shift_reg=0, digit_cnt=0, err=0, err_char=0x00; char_ready SHALL therefore be 1.
REQ-030 Reset SHALL take priority over all handshakes; a reset mid-word or in HOLD SHALL discard the partial or pending word with no word transfer.

Verification
REQ-031 A bench SHALL check the following: the stream "1234ABCD" sent back-to-back with word_ready=1 produces word_out=0x1234ABCD and word_valid=1 for one cycle, starting the cycle after the 'D' is accepted.
REQ-032 A bench SHALL check the following: the stream "deadbeef" in lower case produces word_out=0xDEADBEEF.
REQ-033 A bench SHALL check the following: the stream "12G4" produces err=1 one cycle after 'G', with err_char=0x47 and digit_cnt=0; the following "0000FFFF" then produces 0x0000FFFF.
REQ-034 A bench SHALL check the following: with word_ready=0 after "CAFEF00D", word_valid stays 1 and char_ready stays 0 for 10 cycles while '9' is offered and not accepted; raising word_ready consumes 0xCAFEF00D, and only then is '9' accepted with digit_cnt=1.
REQ-035 A bench SHALL check the following: asserting rst after "ABC" has been accepted, then sending "00000001", produces 0x00000001, not a value containing 0xABC.
REQ-036 A bench SHALL check the following: char_valid toggling 1/0 on alternate cycles across "FFFFFFFF" still produces 0xFFFFFFFF, and word_valid never asserts before the 8th digit.
